// File: rtl/alu_cmd_driver_if.sv
// Command/response channel between a requester (master) and alu_cmd_driver (slave).
// Signal names carry the driver's own direction prefixes.
interface alu_cmd_driver_if #(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_OUT      = 8
);
  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [NB_OPERANDO-1:0] i_cmd_a;
  logic [NB_OPERANDO-1:0] i_cmd_b;
  logic [NB_OPCODE-1:0]   i_cmd_op;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [NB_OUT-1:0]      o_result;

  modport master (
    output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_result
  );

  modport slave (
    input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_result
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Sequences one ALU command onto the switch/button inputs of an ALU top,
// waits for the result to settle, then offers it on a valid/ready response.
module alu_cmd_driver #(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_OUT      = 8,
  parameter int N_WAIT      = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  alu_cmd_driver_if.slave        io_cmd,
  output logic [NB_OPERANDO-1:0] o_switch,
  output logic                   o_boton_1,
  output logic                   o_boton_2,
  output logic                   o_boton_3,
  output logic                   o_boton_4,
  input  logic [NB_OUT-1:0]      i_out,
  output logic                   o_busy,
  output logic [15:0]            o_done_count
);
  localparam int NB_WCNT = (N_WAIT < 2) ? 1 : $clog2(N_WAIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_LOAD_OP = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_WAIT    = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [NB_OPERANDO-1:0] r_a;
  logic [NB_OPERANDO-1:0] r_b;
  logic [NB_OPCODE-1:0]   r_op;
  logic [NB_WCNT-1:0]     r_wcnt;
  logic [NB_OPERANDO-1:0] r_switch;
  logic [NB_OPERANDO-1:0] w_switch;
  logic [3:0]             r_strobe;
  logic [3:0]             w_strobe;
  logic                   r_cmd_ready;
  logic                   r_busy;
  logic                   r_rsp_valid;
  logic [NB_OUT-1:0]      r_result;
  logic [15:0]            r_done_count;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_done;

  // Next-state decode plus the single-cycle accept/capture/done events
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_cmd.i_cmd_valid && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_next_state = ST_LOAD_A;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD_A:  w_next_state = ST_LOAD_B;
      ST_LOAD_B:  w_next_state = ST_LOAD_OP;
      ST_LOAD_OP: w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_wcnt <= NB_WCNT'(1)) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (io_cmd.i_rsp_ready) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ALU-side outputs decoded from the upcoming state so they can be registered
  always_comb begin
    w_switch = {NB_OPERANDO{1'b0}};
    w_strobe = 4'b0000;
    case (w_next_state)
      ST_LOAD_A: begin
        w_switch = io_cmd.i_cmd_a;
        w_strobe = 4'b0001;
      end
      ST_LOAD_B: begin
        w_switch = r_b;
        w_strobe = 4'b0010;
      end
      ST_LOAD_OP: begin
        w_switch = NB_OPERANDO'(r_op);
        w_strobe = 4'b0100;
      end
      ST_CAPTURE: begin
        w_switch = {NB_OPERANDO{1'b0}};
        w_strobe = 4'b1000;
      end
      default: begin
        w_switch = {NB_OPERANDO{1'b0}};
        w_strobe = 4'b0000;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Command operands are latched only on accept so later input changes are ignored
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_a  <= {NB_OPERANDO{1'b0}};
      r_b  <= {NB_OPERANDO{1'b0}};
      r_op <= {NB_OPCODE{1'b0}};
    end else if (w_accept) begin
      r_a  <= io_cmd.i_cmd_a;
      r_b  <= io_cmd.i_cmd_b;
      r_op <= io_cmd.i_cmd_op;
    end else begin
      r_a  <= r_a;
      r_b  <= r_b;
      r_op <= r_op;
    end
  end

  // Settling counter: loaded while capturing, counts down through WAIT
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wcnt <= {NB_WCNT{1'b0}};
    end else if (r_state == ST_CAPTURE) begin
      r_wcnt <= NB_WCNT'(N_WAIT);
    end else if ((r_state == ST_WAIT) && (r_wcnt != {NB_WCNT{1'b0}})) begin
      r_wcnt <= r_wcnt - NB_WCNT'(1);
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  // Registered outputs; ready stays low until the first edge after reset release
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_switch     <= {NB_OPERANDO{1'b0}};
      r_strobe     <= 4'b0000;
      r_cmd_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_result     <= {NB_OUT{1'b0}};
      r_done_count <= 16'h0000;
    end else begin
      r_switch     <= w_switch;
      r_strobe     <= w_strobe;
      r_cmd_ready  <= (w_next_state == ST_IDLE);
      r_busy       <= (w_next_state != ST_IDLE);
      r_rsp_valid  <= (w_next_state == ST_RESP);
      r_result     <= w_capture ? i_out : r_result;
      r_done_count <= w_done ? (r_done_count + 16'h0001) : r_done_count;
    end
  end

  assign o_switch           = r_switch;
  assign o_boton_1          = r_strobe[0];
  assign o_boton_2          = r_strobe[1];
  assign o_boton_3          = r_strobe[2];
  assign o_boton_4          = r_strobe[3];
  assign o_busy             = r_busy;
  assign o_done_count       = r_done_count;
  assign io_cmd.o_cmd_ready = r_cmd_ready;
  assign io_cmd.o_rsp_valid = r_rsp_valid;
  assign io_cmd.o_result    = r_result;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU tops, a command-timeline model with
// a per-cycle compare, and directed vectors with literal expectations.
module tb_alu_cmd_driver;
  localparam int NW     = 2;
  localparam int RESP_K = 5 + NW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_cmd_driver_if #(.NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8)) c0 ();
  alu_cmd_driver_if #(.NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8)) c1 ();

  logic [7:0]  sw0, sw1, out0, out1;
  logic        b0_1, b0_2, b0_3, b0_4, b1_1, b1_2, b1_3, b1_4;
  logic        busy0, busy1;
  logic [15:0] cnt0, cnt1;
  wire  [3:0]  st0 = {b0_4, b0_3, b0_2, b0_1};
  wire  [3:0]  st1 = {b1_4, b1_3, b1_2, b1_1};

  alu_cmd_driver #(.NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8), .N_WAIT(NW)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .io_cmd(c0), .o_switch(sw0),
    .o_boton_1(b0_1), .o_boton_2(b0_2), .o_boton_3(b0_3), .o_boton_4(b0_4),
    .i_out(out0), .o_busy(busy0), .o_done_count(cnt0));

  alu_cmd_driver #(.NB_OPERANDO(8), .NB_OPCODE(6), .NB_OUT(8), .N_WAIT(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .io_cmd(c1), .o_switch(sw1),
    .o_boton_1(b1_1), .o_boton_2(b1_2), .o_boton_3(b1_3), .o_boton_4(b1_4),
    .i_out(out1), .o_busy(busy1), .o_done_count(cnt1));

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ALU tops: buttons load registers, button 4 registers the result
  logic [7:0] a0_r, bb0_r, a1_r, bb1_r;
  logic [5:0] op0_r, op1_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_r <= 8'h00; bb0_r <= 8'h00; op0_r <= 6'h00; out0 <= 8'h00;
      a1_r <= 8'h00; bb1_r <= 8'h00; op1_r <= 6'h00; out1 <= 8'h00;
    end else begin
      if (b0_1) a0_r  <= sw0;
      if (b0_2) bb0_r <= sw0;
      if (b0_3) op0_r <= sw0[5:0];
      if (b0_4) out0  <= alu_f(a0_r, bb0_r, op0_r);
      if (b1_1) a1_r  <= sw1;
      if (b1_2) bb1_r <= sw1;
      if (b1_3) op1_r <= sw1[5:0];
      if (b1_4) out1  <= alu_f(a1_r, bb1_r, op1_r);
    end
  end

  // Timeline model of dut0: m_k counts cycles since the accept edge
  logic        m_active, m_ready;
  int          m_k;
  logic [7:0]  m_a, m_b, m_result;
  logic [5:0]  m_op;
  logic [15:0] m_done;
  logic [15:0] cnt_base = 16'h0000;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_ready <= 1'b0; m_k <= 0; m_a <= 8'h00; m_b <= 8'h00;
      m_op <= 6'h00; m_result <= 8'h00; m_done <= 16'h0000;
    end else if (!m_active) begin
      if (c0.i_cmd_valid && m_ready) begin
        m_active <= 1'b1; m_ready <= 1'b0; m_k <= 1;
        m_a <= c0.i_cmd_a; m_b <= c0.i_cmd_b; m_op <= c0.i_cmd_op;
      end else begin
        m_ready <= 1'b1;
      end
    end else if (m_k >= RESP_K) begin
      if (c0.i_rsp_ready) begin
        m_active <= 1'b0; m_ready <= 1'b1; m_done <= m_done + 16'h0001;
      end
    end else begin
      if (m_k == RESP_K - 1) m_result <= alu_f(m_a, m_b, m_op);
      m_k <= m_k + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [7:0] e_sw;
    logic [3:0] e_st;
    e_sw = 8'h00;
    e_st = 4'b0000;
    if (m_active) begin
      case (m_k)
        1: begin e_sw = m_a;      e_st = 4'b0001; end
        2: begin e_sw = m_b;      e_st = 4'b0010; end
        3: begin e_sw = 8'(m_op); e_st = 4'b0100; end
        4: begin e_sw = 8'h00;    e_st = 4'b1000; end
        default: begin e_sw = 8'h00; e_st = 4'b0000; end
      endcase
    end
    chk("model_cmd_ready", 32'(c0.o_cmd_ready), 32'(m_ready));
    chk("model_busy", 32'(busy0), 32'(m_active));
    chk("model_switch", 32'(sw0), 32'(e_sw));
    chk("model_strobes", 32'(st0), 32'(e_st));
    chk("model_rsp_valid", 32'(c0.o_rsp_valid), 32'(m_active && (m_k >= RESP_K)));
    chk("model_result", 32'(c0.o_result), 32'(m_result));
    chk("model_done_count", 32'(cnt0), 32'(16'(cnt_base + m_done)));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready0();
    int n = 0;
    while ((c0.o_cmd_ready !== 1'b1) && (n < 50)) begin
      cyc();
      n++;
    end
    chk("cmd_ready_wait", 32'(c0.o_cmd_ready), 32'd1);
  endtask

  // Presents one command on c0; returns at #1 into the cycle after the accept edge
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    wait_ready0();
    c0.i_cmd_valid = 1'b1; c0.i_cmd_a = a; c0.i_cmd_b = b; c0.i_cmd_op = op;
    cyc();
    c0.i_cmd_valid = 1'b0;
  endtask

  initial begin
    int n_b1, n_b4, n_rv;
    rst_n = 1'b1;
    c0.i_cmd_valid = 1'b0; c0.i_cmd_a = 8'h00; c0.i_cmd_b = 8'h00; c0.i_cmd_op = 6'h00; c0.i_rsp_ready = 1'b0;
    c1.i_cmd_valid = 1'b0; c1.i_cmd_a = 8'h00; c1.i_cmd_b = 8'h00; c1.i_cmd_op = 6'h00; c1.i_rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none

    // Reset state, then ready on the first edge after release
    @(negedge clk); #1;
    chk("reset_ready", 32'(c0.o_cmd_ready), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_switch", 32'(sw0), 32'h00);
    chk("reset_count", 32'(cnt0), 32'h0000);
    #2 rst_n = 1'b1;
    cyc();
    chk("ready_after_reset", 32'(c0.o_cmd_ready), 32'd1);

    // 05 + 03: strobe sequence and response at +7
    c0.i_rsp_ready = 1'b1;
    send0(8'h05, 8'h03, 6'h20);
    chk("t1_p1_sw", 32'(sw0), 32'h05); chk("t1_p1_st", 32'(st0), 32'h1);
    cyc(); chk("t1_p2_sw", 32'(sw0), 32'h03); chk("t1_p2_st", 32'(st0), 32'h2);
    cyc(); chk("t1_p3_sw", 32'(sw0), 32'h20); chk("t1_p3_st", 32'(st0), 32'h4);
    cyc(); chk("t1_p4_sw", 32'(sw0), 32'h00); chk("t1_p4_st", 32'(st0), 32'h8);
    cyc(); cyc(); chk("t1_p6_rv", 32'(c0.o_rsp_valid), 32'd0);
    cyc(); chk("t1_p7_rv", 32'(c0.o_rsp_valid), 32'd1); chk("t1_p7_res", 32'(c0.o_result), 32'h08);
    cyc(); chk("t1_p8_cnt", 32'(cnt0), 32'd1); chk("t1_p8_busy", 32'(busy0), 32'd0);

    // FF + 01 wraps to 00; response held while the consumer stalls
    c0.i_rsp_ready = 1'b0;
    send0(8'hFF, 8'h01, 6'h20);
    repeat (6) cyc();
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_rv", 32'(c0.o_rsp_valid), 32'd1);
      chk("t2_hold_res", 32'(c0.o_result), 32'h00);
      chk("t2_hold_cnt", 32'(cnt0), 32'd1);
      cyc();
    end
    c0.i_rsp_ready = 1'b1;
    cyc();
    chk("t2_cnt", 32'(cnt0), 32'd2); chk("t2_rv_drop", 32'(c0.o_rsp_valid), 32'd0);

    // Valid held high with changing A while busy: exactly one command runs
    wait_ready0();
    c0.i_cmd_valid = 1'b1; c0.i_cmd_a = 8'h11; c0.i_cmd_b = 8'h22; c0.i_cmd_op = 6'h20;
    cyc();
    n_b1 = 0; n_b4 = 0;
    for (int k = 1; k <= 8; k++) begin
      n_b1 += int'(b0_1);
      n_b4 += int'(b0_4);
      c0.i_cmd_a = 8'h40 + 8'(k);
      if (k == 7) c0.i_cmd_valid = 1'b0;
      cyc();
    end
    chk("t3_one_b1", 32'(n_b1), 32'd1); chk("t3_one_b4", 32'(n_b4), 32'd1);
    chk("t3_res", 32'(c0.o_result), 32'h33); chk("t3_cnt", 32'(cnt0), 32'd3);

    // Reset during LOAD_OP drops the command immediately
    send0(8'h05, 8'h03, 6'h20);
    cyc(); cyc();
    chk("t4_in_loadop", 32'(st0), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_st", 32'(st0), 32'h0); chk("t4_rst_sw", 32'(sw0), 32'h00);
    chk("t4_rst_ready", 32'(c0.o_cmd_ready), 32'd0); chk("t4_rst_busy", 32'(busy0), 32'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    cyc();
    chk("t4_ready_after", 32'(c0.o_cmd_ready), 32'd1);
    n_b4 = 0; n_rv = 0;
    for (int k = 0; k < 10; k++) begin
      n_b4 += int'(b0_4);
      n_rv += int'(c0.o_rsp_valid);
      cyc();
    end
    chk("t4_no_b4", 32'(n_b4), 32'd0); chk("t4_no_rsp", 32'(n_rv), 32'd0);
    chk("t4_cnt", 32'(cnt0), 32'd0);

    // Done counter wraps FFFF -> 0000
    force dut0.r_done_count = 16'hFFFF;
    cnt_base = 16'hFFFF - m_done;
    #1 release dut0.r_done_count;
    cyc();
    chk("t5_preload", 32'(cnt0), 32'hFFFF);
    send0(8'h01, 8'h02, 6'h20);
    repeat (7) cyc();
    chk("t5_wrap", 32'(cnt0), 32'h0000); chk("t5_res", 32'(c0.o_result), 32'h03);

    // N_WAIT=1 instance: 09 - 04, response at +6
    c1.i_rsp_ready = 1'b1;
    chk("t6_ready", 32'(c1.o_cmd_ready), 32'd1);
    c1.i_cmd_valid = 1'b1; c1.i_cmd_a = 8'h09; c1.i_cmd_b = 8'h04; c1.i_cmd_op = 6'h22;
    cyc();
    c1.i_cmd_valid = 1'b0;
    chk("t6_p1_sw", 32'(sw1), 32'h09); chk("t6_p1_st", 32'(st1), 32'h1);
    repeat (4) cyc();
    chk("t6_p5_rv", 32'(c1.o_rsp_valid), 32'd0);
    cyc();
    chk("t6_p6_rv", 32'(c1.o_rsp_valid), 32'd1); chk("t6_p6_res", 32'(c1.o_result), 32'h05);
    cyc();
    chk("t6_cnt", 32'(cnt1), 32'd1); chk("t6_rv_drop", 32'(c1.o_rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 Parameter NB_OPERANDO, default 8, width of operands A/B and of o_switch.
REQ-002 Parameter NB_OPCODE, default 6, opcode width; SHALL be <= NB_OPERANDO.
REQ-003 Parameter NB_OUT, default 8, width of the ALU result bus sampled from the ALU top.
REQ-004 Parameter N_WAIT, default 2, minimum 1, cycles between result-capture strobe and result sampling.
REQ-005 i_clk  input  1  single clock; all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 i_cmd_valid  input  1  command present.
REQ-008 o_cmd_ready  output  1  driver can accept a command.
REQ-009 i_cmd_a  input  NB_OPERANDO  operand A.
REQ-010 i_cmd_b  input  NB_OPERANDO  operand B.
REQ-011 i_cmd_op  input  NB_OPCODE  ALU opcode.
REQ-012 o_switch  output  NB_OPERANDO  value presented to ALU top switch input.
REQ-013 o_boton_1 / o_boton_2 / o_boton_3 / o_boton_4  output  1 each  load-A / load-B / load-opcode / capture-result strobes to ALU top.
REQ-014 i_out  input  NB_OUT  registered result from ALU top.
REQ-015 o_rsp_valid  output  1  result available.
REQ-016 i_rsp_ready  input  1  consumer accepts result.
REQ-017 o_result  output  NB_OUT  captured result.
REQ-018 o_busy  output  1  high in every state except IDLE.
REQ-019 o_done_count  output  16  number of completed response handshakes.

Function
REQ-020 FSM states SHALL be IDLE, LOAD_A, LOAD_B, LOAD_OP, CAPTURE, WAIT, RESP.
REQ-021 o_cmd_ready SHALL be 1 only in IDLE; command accepted on the edge where i_cmd_valid & o_cmd_ready; A/B/op latched internally on that edge; next state LOAD_A.
REQ-022 LOAD_A: o_switch = latched A, o_boton_1 = 1, one cycle, -> LOAD_B.
REQ-023 LOAD_B: o_switch = latched B, o_boton_2 = 1, one cycle, -> LOAD_OP.
REQ-024 LOAD_OP: o_switch = opcode zero-extended to NB_OPERANDO, o_boton_3 = 1, one cycle, -> CAPTURE.
REQ-025 CAPTURE: o_switch = 0, o_boton_4 = 1, one cycle, -> WAIT.
REQ-026 WAIT: down-counter from N_WAIT; on the edge ending the last WAIT cycle o_result <= i_out and -> RESP.
REQ-027 RESP: o_rsp_valid = 1, o_result stable; on i_rsp_ready edge -> IDLE, o_done_count += 1.
REQ-028 o_done_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-029 Strobes SHALL be one-hot or all zero every cycle; all zero and o_switch = 0 in IDLE, WAIT, RESP.
REQ-030 With N_WAIT=2, o_rsp_valid first high 7 cycles after the accept cycle (LOAD_A=+1 ... RESP=+7).
REQ-031 i_cmd_valid during non-IDLE states SHALL be ignored (not latched); command inputs may change freely after accept.
REQ-032 Response held indefinitely while i_rsp_ready = 0; i_rsp_ready outside RESP SHALL have no effect.
REQ-033 RESP -> IDLE and new accept SHALL NOT overlap: minimum one IDLE cycle between commands.

Reset
REQ-034 i_reset = 0 SHALL immediately force state IDLE, all strobes 0, o_switch 0, o_rsp_valid 0, o_result 0, o_done_count 0, latched A/B/op 0, WAIT counter 0; o_busy 0, o_cmd_ready 0 while asserted.
REQ-035 Reset asserted mid-command SHALL drop the command with no further strobes; after release o_cmd_ready = 1 on the first clock-edge-stable cycle.

Verification
REQ-036 Bench couples driver to a behavioural ALU top (opcode 6'h20 = A+B, 6'h22 = A-B); A=8'h05,B=8'h03,op=6'h20 -> strobes 1,2,3,4 in consecutive cycles with o_switch 05,03,20,00; o_result=8'h08 at cycle +7; count=1.
REQ-037 A=8'hFF,B=8'h01,op=6'h20, i_rsp_ready held 0 for 10 cycles -> o_rsp_valid stays 1, o_result=8'h00 stable, count unchanged until ready.
REQ-038 i_cmd_valid held 1 with changing A during LOAD_B..RESP -> no second accept, driven A unchanged, exactly one set of strobes.
REQ-039 i_reset pulsed low during LOAD_OP -> strobes and o_switch 0 same cycle, no o_boton_4, no response, count 0.
REQ-040 Preload o_done_count to 16'hFFFF via 65535 commands (or force) then one more -> count 16'h0000.
REQ-041 N_WAIT=1 build: A=8'h09,B=8'h04,op=6'h22 -> o_result=8'h05, o_rsp_valid at cycle +6.
